// File: rtl/player_motion_ctrl_if.sv
// Player motion controller bus: per-frame control inputs and registered sprite outputs.
interface player_motion_ctrl_if;
  logic               frame_tick;
  logic [3:0]         btn;
  logic [3:0]         blocked;
  logic               die;
  logic               respawn;
  logic signed [10:0] centerX;
  logic signed [10:0] centerY;
  logic [2:0]         sprite_num;
  logic               moving;
  logic               tile_done;

  modport master (
    output frame_tick, btn, blocked, die, respawn,
    input  centerX, centerY, sprite_num, moving, tile_done
  );

  modport slave (
    input  frame_tick, btn, blocked, die, respawn,
    output centerX, centerY, sprite_num, moving, tile_done
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Tile-based player motion controller: moves the sprite one 32-px tile per accepted
// button press in STEP-pixel increments per frame, with walk animation, death and respawn.
module player_motion_ctrl #(
  parameter logic signed [10:0] X0       = 11'sd64,
  parameter logic signed [10:0] Y0       = 11'sd64,
  parameter logic signed [10:0] XMIN     = 11'sd32,
  parameter logic signed [10:0] XMAX     = 11'sd736,
  parameter logic signed [10:0] YMIN     = 11'sd32,
  parameter logic signed [10:0] YMAX     = 11'sd536,
  parameter int                 STEP     = 4,
  parameter int                 ANIM_DIV = 8
) (
  input logic                 clk,
  input logic                 reset,
  player_motion_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DEAD = 2'd2
  } state_t;

  // Direction codes double as the standing sprite index for that facing.
  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [2:0] SPR_WALK_A = 3'd4;
  localparam logic [2:0] SPR_WALK_B = 3'd5;
  localparam logic [2:0] SPR_DEAD   = 3'd6;

  localparam logic signed [10:0] TILE      = 11'sd32;
  localparam logic signed [10:0] STEP_S    = 11'(STEP);
  localparam logic [5:0]         STEP_U    = 6'(STEP);
  localparam logic [7:0]         ANIM_LAST = 8'(ANIM_DIV - 1);

  state_t             state_r;
  logic signed [10:0] x_r;
  logic signed [10:0] y_r;
  logic [1:0]         dir_r;
  logic [4:0]         pix_cnt_r;
  logic [7:0]         anim_cnt_r;
  logic               walk_b_r;
  logic [2:0]         sprite_r;
  logic               moving_r;
  logic               tile_done_r;

  logic               sel_valid_s;
  logic [1:0]         sel_dir_s;
  logic               sel_blocked_s;
  logic               sel_in_range_s;
  logic               can_move_s;
  logic signed [10:0] x_step_s;
  logic signed [10:0] y_step_s;
  logic [5:0]         pix_sum_s;
  logic               move_done_s;
  logic               anim_wrap_s;

  // Pick the highest-priority pressed button and check that its target tile is enterable.
  always_comb begin
    sel_valid_s    = |bus.btn;
    sel_dir_s      = DIR_RIGHT;
    sel_blocked_s  = bus.blocked[0];
    sel_in_range_s = ((x_r + TILE) <= XMAX);
    if (bus.btn[3]) begin
      sel_dir_s      = DIR_UP;
      sel_blocked_s  = bus.blocked[3];
      sel_in_range_s = ((y_r - TILE) >= YMIN);
    end else if (bus.btn[2]) begin
      sel_dir_s      = DIR_DOWN;
      sel_blocked_s  = bus.blocked[2];
      sel_in_range_s = ((y_r + TILE) <= YMAX);
    end else if (bus.btn[1]) begin
      sel_dir_s      = DIR_LEFT;
      sel_blocked_s  = bus.blocked[1];
      sel_in_range_s = ((x_r - TILE) >= XMIN);
    end else begin
      sel_dir_s      = DIR_RIGHT;
      sel_blocked_s  = bus.blocked[0];
      sel_in_range_s = ((x_r + TILE) <= XMAX);
    end
    can_move_s = sel_valid_s & ~sel_blocked_s & sel_in_range_s;
  end

  // Position after one STEP along the latched direction.
  always_comb begin
    x_step_s = x_r;
    y_step_s = y_r;
    case (dir_r)
      DIR_UP:    y_step_s = y_r - STEP_S;
      DIR_DOWN:  y_step_s = y_r + STEP_S;
      DIR_LEFT:  x_step_s = x_r - STEP_S;
      DIR_RIGHT: x_step_s = x_r + STEP_S;
      default: begin
        x_step_s = x_r;
        y_step_s = y_r;
      end
    endcase
  end

  // The pixel counter is 5 bits, so the 32-px completion is detected on the 6-bit sum.
  always_comb begin
    pix_sum_s   = {1'b0, pix_cnt_r} + STEP_U;
    move_done_s = (pix_sum_s == 6'd32);
    anim_wrap_s = (anim_cnt_r == ANIM_LAST);
  end

  // Main FSM with registered outputs; reset, then die, take precedence over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      x_r         <= X0;
      y_r         <= Y0;
      dir_r       <= DIR_DOWN;
      pix_cnt_r   <= 5'd0;
      anim_cnt_r  <= 8'd0;
      walk_b_r    <= 1'b0;
      sprite_r    <= 3'd0;
      moving_r    <= 1'b0;
      tile_done_r <= 1'b0;
    end else if (bus.die) begin
      state_r     <= DEAD;
      sprite_r    <= SPR_DEAD;
      moving_r    <= 1'b0;
      tile_done_r <= 1'b0;
    end else begin
      tile_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          moving_r <= 1'b0;
          if (bus.frame_tick && sel_valid_s) begin
            dir_r <= sel_dir_s;
            if (can_move_s) begin
              state_r    <= MOVE;
              pix_cnt_r  <= 5'd0;
              anim_cnt_r <= 8'd0;
              walk_b_r   <= 1'b0;
              sprite_r   <= SPR_WALK_A;
              moving_r   <= 1'b1;
            end else begin
              sprite_r <= {1'b0, sel_dir_s};
            end
          end else begin
            sprite_r <= {1'b0, dir_r};
          end
        end
        MOVE: begin
          if (bus.frame_tick) begin
            x_r       <= x_step_s;
            y_r       <= y_step_s;
            pix_cnt_r <= pix_sum_s[4:0];
            if (move_done_s) begin
              state_r     <= IDLE;
              tile_done_r <= 1'b1;
              moving_r    <= 1'b0;
              sprite_r    <= {1'b0, dir_r};
            end else if (anim_wrap_s) begin
              anim_cnt_r <= 8'd0;
              walk_b_r   <= ~walk_b_r;
              sprite_r   <= walk_b_r ? SPR_WALK_A : SPR_WALK_B;
            end else begin
              anim_cnt_r <= anim_cnt_r + 8'd1;
              sprite_r   <= walk_b_r ? SPR_WALK_B : SPR_WALK_A;
            end
          end else begin
            moving_r <= 1'b1;
          end
        end
        DEAD: begin
          if (bus.respawn) begin
            state_r  <= IDLE;
            x_r      <= X0;
            y_r      <= Y0;
            dir_r    <= DIR_DOWN;
            sprite_r <= 3'd0;
            moving_r <= 1'b0;
          end else begin
            sprite_r <= SPR_DEAD;
            moving_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          sprite_r <= {1'b0, dir_r};
          moving_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.centerX    = x_r;
  assign bus.centerY    = y_r;
  assign bus.sprite_num = sprite_r;
  assign bus.moving     = moving_r;
  assign bus.tile_done  = tile_done_r;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench: two DUT configurations share the same random/directed stimulus;
// a tile-level reference model predicts each cycle's outputs into per-DUT queues.
module tb_player_motion_ctrl;

  typedef struct {
    int x;
    int y;
    int spr;
    int mv;
    int td;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  player_motion_ctrl_if bus0 ();
  player_motion_ctrl_if bus1 ();

  player_motion_ctrl u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  player_motion_ctrl #(
    .STEP     (8),
    .ANIM_DIV (2)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // current stimulus as seen by the model
  logic       s_reset;
  logic       s_ft;
  logic [3:0] s_btn;
  logic [3:0] s_blk;
  logic       s_die;
  logic       s_rsp;

  // model state: mode 0 idle, 1 moving, 2 dead
  int m_mode[2], m_x[2], m_y[2], m_face[2], m_ticks[2], m_sx[2], m_sy[2], m_spr[2], m_td[2];

  function automatic int step_of(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  function automatic int anim_of(input int k);
    return (k == 0) ? 8 : 2;
  endfunction

  // facing code: 0 down, 1 up, 2 left, 3 right
  function automatic int dx_of(input int d);
    return (d == 2) ? -1 : ((d == 3) ? 1 : 0);
  endfunction

  function automatic int dy_of(input int d);
    return (d == 1) ? -1 : ((d == 0) ? 1 : 0);
  endfunction

  function automatic int blk_bit(input int d);
    case (d)
      0: return 2;
      1: return 3;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input int k);
    int   st, d, tx, ty;
    bit   legal;
    exp_t e;
    st = step_of(k);
    m_td[k] = 0;
    if (s_reset) begin
      m_mode[k] = 0; m_x[k] = 64; m_y[k] = 64; m_face[k] = 0; m_spr[k] = 0;
    end else if (s_die) begin
      m_mode[k] = 2; m_spr[k] = 6;
    end else if (m_mode[k] == 2) begin
      if (s_rsp) begin
        m_mode[k] = 0; m_x[k] = 64; m_y[k] = 64; m_face[k] = 0; m_spr[k] = 0;
      end
    end else if (m_mode[k] == 0) begin
      if (s_ft && s_btn != 4'd0) begin
        if (s_btn[3]) d = 1;
        else if (s_btn[2]) d = 0;
        else if (s_btn[1]) d = 2;
        else d = 3;
        m_face[k] = d;
        tx = m_x[k] + 32 * dx_of(d);
        ty = m_y[k] + 32 * dy_of(d);
        legal = !s_blk[blk_bit(d)] && tx >= 32 && tx <= 736 && ty >= 32 && ty <= 536;
        if (legal) begin
          m_mode[k] = 1; m_ticks[k] = 0; m_sx[k] = m_x[k]; m_sy[k] = m_y[k]; m_spr[k] = 4;
        end else begin
          m_spr[k] = d;
        end
      end
    end else begin
      if (s_ft) begin
        m_ticks[k] = m_ticks[k] + 1;
        m_x[k] = m_sx[k] + dx_of(m_face[k]) * st * m_ticks[k];
        m_y[k] = m_sy[k] + dy_of(m_face[k]) * st * m_ticks[k];
        if (m_ticks[k] * st == 32) begin
          m_mode[k] = 0; m_td[k] = 1; m_spr[k] = m_face[k];
        end else begin
          m_spr[k] = 4 + ((m_ticks[k] / anim_of(k)) % 2);
        end
      end
    end
    e.x = m_x[k]; e.y = m_y[k]; e.spr = m_spr[k]; e.mv = (m_mode[k] == 1) ? 1 : 0; e.td = m_td[k];
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic cycle(input logic rst, input logic ft, input logic [3:0] b, input logic [3:0] bl,
                       input logic d, input logic rs);
    @(negedge clk);
    s_reset = rst; s_ft = ft; s_btn = b; s_blk = bl; s_die = d; s_rsp = rs;
    reset = rst;
    bus0.frame_tick = ft; bus0.btn = b; bus0.blocked = bl; bus0.die = d; bus0.respawn = rs;
    bus1.frame_tick = ft; bus1.btn = b; bus1.blocked = bl; bus1.die = d; bus1.respawn = rs;
    model_step(0);
    model_step(1);
  endtask

  task automatic frames(input int n, input logic [3:0] b, input logic [3:0] bl);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b1, b, bl, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, b, bl, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic check(input int k, input exp_t e, input logic signed [10:0] ax,
                       input logic signed [10:0] ay, input logic [2:0] as,
                       input logic am, input logic at);
    n_vec++;
    if ($isunknown({ax, ay, as, am, at}) || int'(ax) != e.x || int'(ay) != e.y ||
        int'(as) != e.spr || int'(am) != e.mv || int'(at) != e.td) begin
      n_mis++;
      $display("FAIL dut%0d outputs @%0t: got x=%0d y=%0d spr=%0d mv=%0d td=%0d, expected x=%0d y=%0d spr=%0d mv=%0d td=%0d",
               k, $time, ax, ay, as, am, at, e.x, e.y, e.spr, e.mv, e.td);
    end
  endtask

  // monitor: compare registered outputs just after each active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check(0, e, bus0.centerX, bus0.centerY, bus0.sprite_num, bus0.moving, bus0.tile_done);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check(1, e, bus1.centerX, bus1.centerY, bus1.sprite_num, bus1.moving, bus1.tile_done);
      end
    end
  end

  // stimulus: directed scenarios followed by randomized traffic
  initial begin
    logic       r_rst, r_ft, r_d, r_rs;
    logic [3:0] r_b, r_bl;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_x[k] = 64; m_y[k] = 64; m_face[k] = 0; m_ticks[k] = 0;
      m_sx[k] = 64; m_sy[k] = 64; m_spr[k] = 0; m_td[k] = 0;
    end
    bus0.frame_tick = 1'b0; bus0.btn = 4'd0; bus0.blocked = 4'd0; bus0.die = 1'b0; bus0.respawn = 1'b0;
    bus1.frame_tick = 1'b0; bus1.btn = 4'd0; bus1.blocked = 4'd0; bus1.die = 1'b0; bus1.respawn = 1'b0;

    // one tile right, then idle tick with no buttons
    do_reset();
    frames(9, 4'b0001, 4'b0000);
    frames(1, 4'b0000, 4'b0000);
    // up beats left
    do_reset();
    frames(9, 4'b1010, 4'b0000);
    // walk to XMIN, then blocked-at-edge and blocked-tile refusals
    do_reset();
    frames(9, 4'b0010, 4'b0000);
    frames(1, 4'b0010, 4'b0000);
    frames(1, 4'b0100, 4'b0100);
    // respawn outside DEAD is ignored
    cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    // die mid-move, die+respawn together, then respawn
    do_reset();
    frames(4, 4'b0001, 4'b0000);
    cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    frames(3, 4'b0001, 4'b0000);
    cycle(1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    // reset mid-move
    frames(5, 4'b0100, 4'b0000);
    cycle(1'b1, 1'b1, 4'b0100, 4'd0, 1'b0, 1'b0);
    frames(2, 4'b0000, 4'b0000);
    // two back-to-back tiles with right held
    do_reset();
    frames(18, 4'b0001, 4'b0000);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r_rst = ($urandom_range(0, 599) == 0);
      r_ft  = ($urandom_range(0, 2) == 0);
      r_b   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      r_bl  = 4'($urandom & $urandom);
      r_d   = ($urandom_range(0, 199) == 0);
      r_rs  = ($urandom_range(0, 14) == 0);
      cycle(r_rst, r_ft, r_b, r_bl, r_d, r_rs);
    end

    cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/player_motion_ctrl.md
PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  X0  11'sd64  reset/respawn X (top-left corner of sprite)
  Y0  11'sd64  reset/respawn Y
  XMIN/XMAX  11'sd32 / 11'sd736  inclusive legal X range for sprite corner
  YMIN/YMAX  11'sd32 / 11'sd536  inclusive legal Y range
  STEP  4  pixels per frame while moving; SHALL divide 32
  ANIM_DIV  8  frame ticks per walk-frame toggle
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  pixel clock
  reset  in  1  synchronous, active-high
  frame_tick  in  1  one-cycle pulse per video frame (vblank start)
  btn  in  4  {up,down,left,right} held buttons
  blocked  in  4  {up,down,left,right} neighbour tile not walkable, valid on frame_tick
  die  in  1  one-cycle kill pulse
  respawn  in  1  one-cycle respawn pulse
  centerX  out  11 signed  sprite top-left X, registered
  centerY  out  11 signed  sprite top-left Y, registered
  sprite_num  out  3  sprite index into 7-entry sprite ROM
  moving  out  1  high while in MOVE
  tile_done  out  1  one-cycle pulse when a 32-px move completes

Function
REQ-003 FSM states IDLE, MOVE, DEAD; all state changes occur only on a cycle with frame_tick=1, except die/respawn.
REQ-004 IDLE: on frame_tick, select requested direction by priority up>down>left>right among asserted btn bits; lower-priority bits ignored.
REQ-005 Move SHALL start only if selected direction's blocked bit is 0 and the target corner (current +/-32 on the axis) lies within [XMIN,XMAX]/[YMIN,YMAX]; otherwise stay IDLE, facing updated to selected direction.
REQ-006 On start: latch direction, clear 5-bit pixel counter, enter MOVE; position unchanged that cycle.
REQ-007 MOVE: on each frame_tick, position += STEP along latched direction (up: Y-, down: Y+, left: X-, right: X+), counter += STEP.
REQ-008 When counter reaches 32 on that tick, return to IDLE and pulse tile_done for exactly one cycle; total move = 32/STEP frame ticks.
REQ-009 Buttons are ignored during MOVE; a move is never aborted except by die or reset.
REQ-010 sprite_num encoding: 0 down, 1 up, 2 left, 3 right (standing, facing); 4 walk frame A, 5 walk frame B; 6 dead.
REQ-011 IDLE: sprite_num = facing code. MOVE: alternates 4/5 starting at 4, toggling after every ANIM_DIV frame ticks (anim counter cleared on move start, persists across back-to-back moves only if restarted). DEAD: 6.
REQ-012 die (any state) SHALL enter DEAD next cycle; position frozen, moving=0, no tile_done.
REQ-013 respawn in DEAD SHALL load X0/Y0, facing down, enter IDLE; respawn outside DEAD ignored; die and respawn same cycle: die wins.
REQ-014 All arithmetic 11-bit signed; bounds checks guarantee no wrap.
REQ-015 moving = (state==MOVE); all outputs registered, update one cycle after the triggering input.

Reset
REQ-016 reset SHALL force IDLE, centerX=X0, centerY=Y0, sprite_num=0, moving=0, tile_done=0, counters 0, facing down, overriding all other inputs including mid-move.

Verification
REQ-017 reset, btn=right, blocked=0, 8 frame ticks -> centerX 64->96 in steps of 4, moving high 8 ticks, one tile_done, sprite 4 for ticks 1-8 then 3.
REQ-018 btn=up|left at IDLE (64,64), blocked up=0 -> Y moves to 32, X unchanged (priority up wins).
REQ-019 At (32,64) btn=left -> no move (XMIN), sprite_num=2, moving=0; btn=down with blocked down=1 -> no move, sprite_num=0.
REQ-020 die after 3 move ticks -> sprite 6, position frozen at 76, no tile_done; respawn -> (64,64), sprite 0.
REQ-021 reset asserted mid-move -> next cycle (64,64), IDLE, tile_done never pulses.
REQ-022 Continuous right held 2 tiles, ANIM_DIV=8 -> 16 ticks, two tile_done pulses, X 64->128.
